hazard_ctrl: RTL and testbench
==============================

Name: hazard_ctrl

Overview:
- Central hazard and sequencing controller for the 5-stage pipeline (F, D, E, M, W).
- Drives the stall and flush inputs of the F/D, D/E and E/M pipeline registers, including the decode-to-execute register.
- Drives the execute-stage forwarding muxes.
- Sequences multi-cycle execute operations with a small FSM and down-counter, freezing the front of the pipe and injecting bubbles into M until the operation completes.

Parameters:
- MC_LAT, 4, total cycles a multi-cycle op occupies E (legal range 1..16).
- REGW, 4, register address width (16 architectural registers).

Ports:
- clk  in  1  clock.
- rst  in  1  reset, asynchronous, active-high.
- RA1E  in  REGW  source register 1 of instruction in E.
- RA2E  in  REGW  source register 2 of instruction in E.
- RA1D  in  REGW  source register 1 of instruction in D.
- RA2D  in  REGW  source register 2 of instruction in D.
- WA3E  in  REGW  destination register in E.
- WA3M  in  REGW  destination register in M.
- WA3W  in  REGW  destination register in W.
- RegWriteM  in  1  M-stage instruction writes the register file.
- RegWriteW  in  1  W-stage instruction writes the register file.
- MemtoRegE  in  1  E-stage instruction is a load.
- BranchTakenE  in  1  branch resolved taken in E.
- mcStartE  in  1  instruction in E is a multi-cycle op; single-cycle pulse on first E cycle.
- StallF  out  1  hold PC.
- StallD  out  1  hold F/D register.
- StallE  out  1  hold D/E register.
- FlushD  out  1  clear F/D register.
- FlushE  out  1  clear D/E register.
- FlushM  out  1  clear E/M register (bubble).
- ForwardAE  out  2  operand A source: 00 RF, 01 W result, 10 M result.
- ForwardBE  out  2  operand B source, same encoding as ForwardAE.
- mcBusy  out  1  FSM in BUSY.
- mcDone  out  1  last E cycle of multi-cycle op.

Behaviour:
- Reset: state RUN, cnt 0. While rst is high, all outputs are 0.
- FSM state is registered. All outputs are combinational from state, cnt and inputs; there is no added latency.
- Forwarding, per operand X in {A, B}:
  - 10 if RegWriteM & (WA3M == RAXE) & (RAXE != 15).
  - Otherwise 01 if RegWriteW & (WA3W == RAXE) & (RAXE != 15).
  - Otherwise 00.
  - M has priority over W when both match.
  - Register 15 (PC) is never forwarded.
- mcStall = (RUN & mcStartE & MC_LAT > 1) | (BUSY & cnt != 0).
- mcDone = (BUSY & cnt == 0) | (RUN & mcStartE & MC_LAT == 1).
- FSM transitions:
  - RUN to BUSY: mcStartE & MC_LAT > 1; load cnt = MC_LAT-2.
  - BUSY with cnt != 0: cnt decrements.
  - BUSY with cnt == 0: go to RUN.
  - mcStartE is ignored in BUSY.
- Stall cycles: an op occupies E for exactly MC_LAT cycles, with MC_LAT-1 stall cycles.
- mcStall effect: StallF = StallD = StallE = 1 and FlushM = 1; FlushD = FlushE = 0.
- Load-use hazard:
  - ldStall = MemtoRegE & ((WA3E == RA1D) | (WA3E == RA2D)) & !mcStall.
  - Effect: StallF = StallD = 1, FlushE = 1, StallE = 0.
- Branch:
  - BranchTakenE & !mcStall gives FlushD = FlushE = 1.
  - The branch overrides ldStall stalls: StallF = StallD = 0, since the fetch must redirect.
- Priority: mcStall > BranchTakenE > ldStall.
- Simultaneous BranchTakenE & mcStartE is an encoding error: the branch wins, mcStartE is ignored, and the FSM stays in RUN.
- Invariant: FlushE is never asserted together with StallE; an op held in E is never killed.
- Reset mid-operation: the FSM returns to RUN and cnt clears asynchronously, so no stall persists.

Decomposition:
- Package hazard_pkg holds:
  - fwd_sel_t enum (FWD_RF = 2'b00, FWD_WB = 2'b01, FWD_MEM = 2'b10).
  - mc_state_t enum (RUN, BUSY).
  - Constant REG_PC = 4'hF.
- Sub-module fwd_sel: a combinational single-operand forwarding selector, instantiated twice (operand A and operand B).

Test Plan:
- Forwarding:
  - Stimulus: RegWriteM=1, WA3M=3, RegWriteW=1, WA3W=3, RA1E=3, RA2E=15.
  - Response: ForwardAE=10, ForwardBE=00.
  - Then drop RegWriteM: ForwardAE=01.
- Load-use:
  - Stimulus: MemtoRegE=1, WA3E=5, RA2D=5.
  - Response: StallF=StallD=FlushE=1, StallE=0 for one cycle; all stall/flush outputs 0 after the load leaves E.
- Branch:
  - Stimulus: BranchTakenE=1 with the load-use condition also true.
  - Response: FlushD=FlushE=1, StallF=StallD=0.
- Multi-cycle, MC_LAT=4:
  - Stimulus: pulse mcStartE at cycle t.
  - Response: StallE=FlushM=1 at t, t+1, t+2; mcDone=1 and StallE=0 at t+3; mcBusy=1 on t+1..t+3; RUN at t+4.
  - Also: a load-use condition held during t..t+2 produces FlushE=0.
- Reset mid-op:
  - Stimulus: assert rst at t+1 of a MC_LAT=4 op.
  - Response: outputs 0 immediately; after release, mcBusy=0 and no stalls.
- MC_LAT=1 build:
  - Stimulus: pulse mcStartE.
  - Response: mcDone=1 in the same cycle, no stall, FSM remains in RUN.

Source files
------------

// File: rtl/hazard_pkg.sv
// Shared types and constants for the pipeline hazard controller.
package hazard_pkg;

   typedef enum logic [1:0] {
      FWD_RF  = 2'b00,
      FWD_WB  = 2'b01,
      FWD_MEM = 2'b10
   } fwd_sel_t;

   typedef enum logic {
      RUN  = 1'b0,
      BUSY = 1'b1
   } mc_state_t;

   localparam logic [3:0] REG_PC = 4'hF;

   // Holds MC_LAT-2 for the largest legal latency of 16.
   localparam int unsigned CNT_W = 4;

endpackage

// File: rtl/fwd_sel.sv
// Single-operand forwarding selector for the execute stage.
module fwd_sel
   import hazard_pkg::*;
#(
   parameter int unsigned REGW = 4
) (
   input  logic [REGW-1:0] ra_i,
   input  logic [REGW-1:0] wa_m_i,
   input  logic [REGW-1:0] wa_w_i,
   input  logic            reg_write_m_i,
   input  logic            reg_write_w_i,
   output fwd_sel_t        sel_o
);

   localparam logic [REGW-1:0] PcAddr = REGW'(REG_PC);

   // The PC is never a forwarding target; M wins over W.
   always_comb begin
      sel_o = FWD_RF;
      if (ra_i != PcAddr) begin
         if (reg_write_m_i && (wa_m_i == ra_i)) begin
            sel_o = FWD_MEM;
         end else if (reg_write_w_i && (wa_w_i == ra_i)) begin
            sel_o = FWD_WB;
         end
      end
   end

endmodule

// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller: forwarding, load-use and branch handling, and
// sequencing of multi-cycle execute operations.
module hazard_ctrl
   import hazard_pkg::*;
#(
   parameter int unsigned MC_LAT = 4,
   parameter int unsigned REGW   = 4
) (
   input  logic            clk,
   input  logic            rst,
   input  logic [REGW-1:0] RA1E,
   input  logic [REGW-1:0] RA2E,
   input  logic [REGW-1:0] RA1D,
   input  logic [REGW-1:0] RA2D,
   input  logic [REGW-1:0] WA3E,
   input  logic [REGW-1:0] WA3M,
   input  logic [REGW-1:0] WA3W,
   input  logic            RegWriteM,
   input  logic            RegWriteW,
   input  logic            MemtoRegE,
   input  logic            BranchTakenE,
   input  logic            mcStartE,
   output logic            StallF,
   output logic            StallD,
   output logic            StallE,
   output logic            FlushD,
   output logic            FlushE,
   output logic            FlushM,
   output logic [1:0]      ForwardAE,
   output logic [1:0]      ForwardBE,
   output logic            mcBusy,
   output logic            mcDone
);

   localparam bit MultiCycle = (MC_LAT > 1);
   localparam logic [CNT_W-1:0] CntLoad = MultiCycle ? CNT_W'(MC_LAT - 32'd2) : '0;

   mc_state_t        state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;

   fwd_sel_t fwd_a, fwd_b;
   logic     mc_start, mc_stall, mc_done, br_flush, ld_stall;

   fwd_sel #(
      .REGW(REGW)
   ) u_fwd_a (
      .ra_i         (RA1E),
      .wa_m_i       (WA3M),
      .wa_w_i       (WA3W),
      .reg_write_m_i(RegWriteM),
      .reg_write_w_i(RegWriteW),
      .sel_o        (fwd_a)
   );

   fwd_sel #(
      .REGW(REGW)
   ) u_fwd_b (
      .ra_i         (RA2E),
      .wa_m_i       (WA3M),
      .wa_w_i       (WA3W),
      .reg_write_m_i(RegWriteM),
      .reg_write_w_i(RegWriteW),
      .sel_o        (fwd_b)
   );

   // A taken branch in E kills a simultaneous multi-cycle start.
   assign mc_start = mcStartE & ~BranchTakenE & (state_q == RUN);
   assign mc_stall = (mc_start & MultiCycle) | ((state_q == BUSY) & (cnt_q != '0));
   assign mc_done  = ((state_q == BUSY) & (cnt_q == '0)) | (mc_start & ~MultiCycle);
   assign br_flush = BranchTakenE & ~mc_stall;
   assign ld_stall = MemtoRegE & ((WA3E == RA1D) | (WA3E == RA2D)) & ~mc_stall;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= RUN;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
      end
   end

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      unique case (state_q)
         RUN: begin
            if (mc_start && MultiCycle) begin
               state_d = BUSY;
               cnt_d   = CntLoad;
            end
         end
         BUSY: begin
            if (cnt_q != '0) begin
               cnt_d = cnt_q - CNT_W'(1);
            end else begin
               state_d = RUN;
            end
         end
      endcase
   end

   always_comb begin
      StallF    = 1'b0;
      StallD    = 1'b0;
      StallE    = 1'b0;
      FlushD    = 1'b0;
      FlushE    = 1'b0;
      FlushM    = 1'b0;
      ForwardAE = 2'b00;
      ForwardBE = 2'b00;
      mcBusy    = 1'b0;
      mcDone    = 1'b0;
      if (!rst) begin
         // The branch must redirect fetch, so it releases load-use stalls.
         StallF    = mc_stall | (ld_stall & ~br_flush);
         StallD    = mc_stall | (ld_stall & ~br_flush);
         StallE    = mc_stall;
         FlushD    = br_flush;
         FlushE    = br_flush | ld_stall;
         FlushM    = mc_stall;
         ForwardAE = fwd_a;
         ForwardBE = fwd_b;
         mcBusy    = (state_q == BUSY);
         mcDone    = mc_done;
      end
   end

endmodule

// File: tb/tb_hazard_ctrl.sv
// Self-checking bench for hazard_ctrl: directed cases plus randomized stimulus
// against a position-counting reference model, for MC_LAT=4 and MC_LAT=1 builds.
module tb_hazard_ctrl;

   localparam int L4 = 4;
   localparam int L1 = 1;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic [3:0] RA1E = '0, RA2E = '0, RA1D = '0, RA2D = '0;
   logic [3:0] WA3E = '0, WA3M = '0, WA3W = '0;
   logic       RegWriteM = 1'b0, RegWriteW = 1'b0, MemtoRegE = 1'b0;
   logic       BranchTakenE = 1'b0, mcStartE = 1'b0;

   logic       StallF, StallD, StallE, FlushD, FlushE, FlushM, mcBusy, mcDone;
   logic [1:0] ForwardAE, ForwardBE;
   logic       StallF1, StallD1, StallE1, FlushD1, FlushE1, FlushM1, mcBusy1, mcDone1;
   logic [1:0] ForwardAE1, ForwardBE1;

   int checks = 0;
   int failures = 0;
   int pos4 = -1;
   int pos1 = -1;

   always #5 clk = ~clk;

   hazard_ctrl #(.MC_LAT(L4), .REGW(4)) dut (
      .clk(clk), .rst(rst), .RA1E(RA1E), .RA2E(RA2E), .RA1D(RA1D), .RA2D(RA2D),
      .WA3E(WA3E), .WA3M(WA3M), .WA3W(WA3W), .RegWriteM(RegWriteM), .RegWriteW(RegWriteW),
      .MemtoRegE(MemtoRegE), .BranchTakenE(BranchTakenE), .mcStartE(mcStartE),
      .StallF(StallF), .StallD(StallD), .StallE(StallE), .FlushD(FlushD), .FlushE(FlushE),
      .FlushM(FlushM), .ForwardAE(ForwardAE), .ForwardBE(ForwardBE), .mcBusy(mcBusy),
      .mcDone(mcDone)
   );

   hazard_ctrl #(.MC_LAT(L1), .REGW(4)) dut1 (
      .clk(clk), .rst(rst), .RA1E(RA1E), .RA2E(RA2E), .RA1D(RA1D), .RA2D(RA2D),
      .WA3E(WA3E), .WA3M(WA3M), .WA3W(WA3W), .RegWriteM(RegWriteM), .RegWriteW(RegWriteW),
      .MemtoRegE(MemtoRegE), .BranchTakenE(BranchTakenE), .mcStartE(mcStartE),
      .StallF(StallF1), .StallD(StallD1), .StallE(StallE1), .FlushD(FlushD1),
      .FlushE(FlushE1), .FlushM(FlushM1), .ForwardAE(ForwardAE1), .ForwardBE(ForwardBE1),
      .mcBusy(mcBusy1), .mcDone(mcDone1)
   );

   wire [11:0] vec4 = {StallF, StallD, StallE, FlushD, FlushE, FlushM,
                       ForwardAE, ForwardBE, mcBusy, mcDone};
   wire [11:0] vec1 = {StallF1, StallD1, StallE1, FlushD1, FlushE1, FlushM1,
                       ForwardAE1, ForwardBE1, mcBusy1, mcDone1};

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         if (failures <= 40)
            $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
      end
   endtask

   function automatic logic [1:0] fwd(input logic [3:0] ra);
      if (ra == 4'd15) return 2'b00;
      if (RegWriteM && WA3M == ra) return 2'b10;
      if (RegWriteW && WA3W == ra) return 2'b01;
      return 2'b00;
   endfunction

   // pos = how many E cycles the current op has already spent (-1: none).
   function automatic int cur_pos(input int pos);
      if (pos < 0 && mcStartE && !BranchTakenE) return 0;
      return pos;
   endfunction

   function automatic int model_next(input int lat, input int pos);
      int cur;
      cur = cur_pos(pos);
      if (cur >= 0 && cur < lat - 1) return cur + 1;
      return -1;
   endfunction

   function automatic logic [11:0] model_out(input int lat, input int pos);
      int   cur;
      logic stall, done, busy, br, ld;
      if (rst) return 12'h000;
      cur   = cur_pos(pos);
      stall = (cur >= 0) && (cur < lat - 1);
      done  = (cur >= 0) && (cur == lat - 1);
      busy  = (cur >= 1);
      br    = BranchTakenE && !stall;
      ld    = MemtoRegE && (WA3E == RA1D || WA3E == RA2D) && !stall;
      return {stall | (ld & ~br), stall | (ld & ~br), stall, br, br | ld, stall,
              fwd(RA1E), fwd(RA2E), busy, done};
   endfunction

   always @(posedge clk or posedge rst) begin
      if (rst) begin
         pos4 <= -1;
         pos1 <= -1;
      end else begin
         pos4 <= model_next(L4, pos4);
         pos1 <= model_next(L1, pos1);
      end
   end

   always @(negedge clk) begin
      chk("model_lat4", {20'd0, vec4}, {20'd0, model_out(L4, pos4)});
      chk("model_lat1", {20'd0, vec1}, {20'd0, model_out(L1, pos1)});
      chk("flushe_with_stalle", {31'd0, FlushE & StallE}, 32'd0);
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic sample();
      @(negedge clk);
      #1;
   endtask

   task automatic clear_inputs();
      RA1E = '0; RA2E = '0; RA1D = '0; RA2D = '0;
      WA3E = 4'd9; WA3M = '0; WA3W = '0;
      RegWriteM = 1'b0; RegWriteW = 1'b0; MemtoRegE = 1'b0;
      BranchTakenE = 1'b0; mcStartE = 1'b0;
   endtask

   function automatic logic [3:0] rnd_reg();
      int r;
      r = $urandom_range(0, 5);
      return (r == 5) ? 4'd15 : 4'(r);
   endfunction

   initial begin
      clear_inputs();
      sample();
      chk("reset_outputs_zero", {20'd0, vec4}, 32'd0);
      tick();
      rst = 1'b0;

      // Forwarding: M over W, PC never forwarded.
      RegWriteM = 1; WA3M = 3; RegWriteW = 1; WA3W = 3; RA1E = 3; RA2E = 15;
      sample();
      chk("fwd_a_mem", {30'd0, ForwardAE}, 32'd2);
      chk("fwd_b_pc", {30'd0, ForwardBE}, 32'd0);
      tick();
      RegWriteM = 0;
      sample();
      chk("fwd_a_wb", {30'd0, ForwardAE}, 32'd1);

      // Load-use.
      tick();
      clear_inputs();
      MemtoRegE = 1; WA3E = 5; RA1D = 2; RA2D = 5;
      sample();
      chk("lduse_sf_sd_fe_se", {28'd0, StallF, StallD, FlushE, StallE}, 32'b1110);
      tick();
      MemtoRegE = 0;
      sample();
      chk("lduse_released", {26'd0, StallF, StallD, StallE, FlushD, FlushE, FlushM}, 32'd0);

      // Branch overrides load-use.
      tick();
      MemtoRegE = 1; BranchTakenE = 1;
      sample();
      chk("branch_fd_fe_sf_sd", {28'd0, FlushD, FlushE, StallF, StallD}, 32'b1100);

      // Multi-cycle op with a load-use condition held during the stall cycles.
      tick();
      BranchTakenE = 0; mcStartE = 1;
      sample();
      chk("mc_t", {28'd0, StallE, FlushM, mcDone, mcBusy}, 32'b1100);
      chk("mc_t_flushe", {31'd0, FlushE}, 32'd0);
      chk("mc1_done_same_cycle", {29'd0, mcDone1, StallE1, mcBusy1}, 32'b100);
      tick();
      mcStartE = 0;
      sample();
      chk("mc_t1", {28'd0, StallE, FlushM, mcDone, mcBusy}, 32'b1101);
      chk("mc_t1_flushe", {31'd0, FlushE}, 32'd0);
      chk("mc1_idle", {29'd0, mcDone1, StallE1, mcBusy1}, 32'b000);
      tick();
      sample();
      chk("mc_t2", {28'd0, StallE, FlushM, mcDone, mcBusy}, 32'b1101);
      chk("mc_t2_flushe", {31'd0, FlushE}, 32'd0);
      tick();
      MemtoRegE = 0;
      sample();
      chk("mc_t3", {28'd0, StallE, FlushM, mcDone, mcBusy}, 32'b0011);
      tick();
      sample();
      chk("mc_t4", {28'd0, StallE, FlushM, mcDone, mcBusy}, 32'b0000);

      // Reset in the middle of an op.
      tick();
      mcStartE = 1;
      tick();
      mcStartE = 0;
      sample();
      chk("rst_pre_busy", {31'd0, mcBusy}, 32'd1);
      rst = 1'b1;
      #1;
      chk("rst_mid_zero", {20'd0, vec4}, 32'd0);
      tick();
      rst = 1'b0;
      sample();
      chk("rst_after", {29'd0, mcBusy, StallE, FlushM}, 32'd0);

      // Randomized traffic; the compare process checks every cycle.
      for (int i = 0; i < 3000; i++) begin
         tick();
         rst          = ($urandom_range(0, 199) == 0);
         RA1E         = rnd_reg();
         RA2E         = rnd_reg();
         RA1D         = rnd_reg();
         RA2D         = rnd_reg();
         WA3E         = rnd_reg();
         WA3M         = rnd_reg();
         WA3W         = rnd_reg();
         RegWriteM    = 1'($urandom_range(0, 1));
         RegWriteW    = 1'($urandom_range(0, 1));
         MemtoRegE    = 1'($urandom_range(0, 1));
         BranchTakenE = ($urandom_range(0, 7) == 0);
         mcStartE     = ($urandom_range(0, 5) == 0);
      end
      tick();
      rst = 1'b0;
      clear_inputs();
      sample();

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
